// File: rtl/btn_pulse_gen.sv
// Push-button conditioning: two-flop synchroniser, press/release debounce,
// single-cycle strobe per press with optional auto-repeat, and a press counter.
module btn_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_pulse,
  output logic       btn_level,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST   = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               REPEAT_EN = (REPEAT_DELAY > 0);

  logic             s1_q, s2_q;
  state_t           state_q;
  logic [CNT_W-1:0] dcnt_q;
  logic [CNT_W-1:0] rcnt_q;
  logic             rep_q;
  logic             pulse_q;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;
  logic             rep_due;

  // rep_q selects the first-repeat delay or the steady repeat period.
  assign rep_due = REPEAT_EN && (rep_q ? (rcnt_q == RP_LAST) : (rcnt_q == RD_LAST));
  assign cnt_d   = cnt_q + 8'd1;

  // NOTE: every register here uses <= so all flops sample pre-edge values;
  // blocking assignments would let s2_q see this edge's s1_q and drop a sync stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      rep_q   <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn_in;
      s2_q    <= s1_q;
      pulse_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (s2_q) begin
            state_q <= DB_PRESS;
            dcnt_q  <= '0;
          end
        end
        DB_PRESS: begin
          if (!s2_q) begin
            state_q <= IDLE;
          end else if (dcnt_q == DB_LAST) begin
            state_q <= HELD;
            pulse_q <= 1'b1;
            cnt_q   <= cnt_d;
            rcnt_q  <= '0;
            rep_q   <= 1'b0;
          end else begin
            dcnt_q <= dcnt_q + CNT_ONE;
          end
        end
        HELD: begin
          // Release wins over a repeat falling due on the same edge.
          if (!s2_q) begin
            state_q <= DB_RELEASE;
            dcnt_q  <= '0;
          end else if (REPEAT_EN) begin
            if (rep_due) begin
              pulse_q <= 1'b1;
              cnt_q   <= cnt_d;
              rcnt_q  <= '0;
              rep_q   <= 1'b1;
            end else begin
              rcnt_q <= rcnt_q + CNT_ONE;
            end
          end
        end
        DB_RELEASE: begin
          if (s2_q) begin
            state_q <= HELD;
            rcnt_q  <= '0;
            rep_q   <= 1'b0;
          end else if (dcnt_q == DB_LAST) begin
            state_q <= IDLE;
          end else begin
            dcnt_q <= dcnt_q + CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign btn_pulse = pulse_q;
  assign btn_level = (state_q == HELD) || (state_q == DB_RELEASE);
  assign press_cnt = cnt_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen: two instances (auto-repeat on / off) on a shared
// button, compared every cycle against a run-length behavioural model.
module tb_btn_pulse_gen;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int CW = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic       pulse_a, level_a, pulse_b, level_b;
  logic [7:0] cnt_a, cnt_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  bit prev_a   = 1'b0;

  always #5 clk = ~clk;

  btn_pulse_gen #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_pulse(pulse_a), .btn_level(level_a), .press_cnt(cnt_a)
  );

  btn_pulse_gen #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP), .CNT_W(CW)) dut_b (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_pulse(pulse_b), .btn_level(level_b), .press_cnt(cnt_b)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the debounced level flips once the delayed button has disagreed
  // with it for DB+1 consecutive edges; repeats follow elapsed-time arithmetic.
  bit m_s1, m_s2, m_smp;
  bit m_level[2];
  int m_run[2];
  int m_since[2];
  bit m_pulse[2];
  int m_cnt[2];

  function automatic int rd_of(input int i);
    return (i == 0) ? RD : 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = 1'b0;
      m_s2 = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_level[i] = 1'b0; m_run[i] = 0; m_since[i] = 0; m_pulse[i] = 1'b0; m_cnt[i] = 0;
      end
    end else begin
      m_smp = m_s2;
      m_s2  = m_s1;
      m_s1  = btn_in;
      for (int i = 0; i < 2; i++) begin
        m_pulse[i] = 1'b0;
        if (m_smp != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            m_level[i] = m_smp;
            m_run[i]   = 0;
            if (m_smp) begin
              m_pulse[i] = 1'b1;
              m_since[i] = 0;
            end
          end
        end else if (m_level[i]) begin
          if (m_run[i] > 0) begin
            m_run[i]   = 0;
            m_since[i] = 0;
          end else begin
            m_since[i]++;
            if (rd_of(i) > 0 && m_since[i] >= rd_of(i) && ((m_since[i] - rd_of(i)) % RP) == 0)
              m_pulse[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
        if (m_pulse[i]) m_cnt[i] = (m_cnt[i] + 1) % 256;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pulse_a", pulse_a, m_pulse[0]);
      check("level_a", level_a, m_level[0]);
      check("cnt_a",   cnt_a,   m_cnt[0]);
      check("pulse_b", pulse_b, m_pulse[1]);
      check("level_b", level_b, m_level[1]);
      check("cnt_b",   cnt_b,   m_cnt[1]);
      check("pulse_a_back_to_back", int'(pulse_a && prev_a), 0);
      prev_a = pulse_a;
    end
  end

  // Counts negedges until dut_a pulses; -1 if none within the budget.
  task automatic wait_pulse(output int n);
    n = -1;
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk);
      if (pulse_a) begin
        n = j;
        break;
      end
    end
  endtask

  task automatic wait_level_low(output int n);
    n = -1;
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk);
      if (!level_a) begin
        n = j;
        break;
      end
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n, pulses, drops, base, len;
    int offs[$];
    int exp_offs[5];
    exp_offs = '{0, 20, 28, 36, 44};

    // 1: reset then first press
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_level", level_a, 0);
    check("rst_pulse", pulse_a, 0);
    check("rst_cnt",   cnt_a,   0);
    rst = 1'b0;
    btn_in = 1'b1;
    wait_pulse(n);
    check("t1_press_latency", n, 7);
    check("t1_level", level_a, 1);
    check("t1_cnt", cnt_a, 1);
    check("t1_model_cnt", m_cnt[0], 1);
    @(negedge clk);
    check("t1_pulse_width", pulse_a, 0);

    // 2: bounce rejection
    btn_in = 1'b0;
    repeat (12) @(negedge clk);
    base = cnt_a;
    btn_in = 1'b1;
    repeat (3) @(negedge clk);
    btn_in = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (pulse_a) pulses++;
    end
    check("t2_bounce_pulses", pulses, 0);
    check("t2_level", level_a, 0);
    check("t2_cnt", cnt_a, base);

    // 3: release bounce, then clean release
    btn_in = 1'b1;
    wait_pulse(n);
    check("t3_press_latency", n, 7);
    repeat (5) @(negedge clk);
    btn_in = 1'b0;
    repeat (2) @(negedge clk);
    btn_in = 1'b1;
    pulses = 0;
    drops = 0;
    repeat (15) begin
      @(negedge clk);
      if (pulse_a) pulses++;
      if (!level_a) drops++;
    end
    check("t3_bounce_level_drops", drops, 0);
    check("t3_bounce_pulses", pulses, 0);
    btn_in = 1'b0;
    wait_level_low(n);
    check("t3_release_latency", n, 7);

    // 4: auto-repeat timing, and no repeats with REPEAT_DELAY = 0
    repeat (4) @(negedge clk);
    pulse_rst();
    check("t4_cnt_after_rst", cnt_a, 0);
    btn_in = 1'b1;
    wait_pulse(n);
    check("t4_press_latency", n, 7);
    offs.delete();
    offs.push_back(0);
    pulses = 0;
    for (int j = 1; j <= 48; j++) begin
      @(negedge clk);
      if (pulse_a) offs.push_back(j);
      if (pulse_b) pulses++;
    end
    btn_in = 1'b0;
    check("t4_repeat_count", offs.size(), 5);
    for (int j = 0; j < 5; j++)
      if (j < offs.size()) check($sformatf("t4_repeat_offset_%0d", j), offs[j], exp_offs[j]);
    check("t4_cnt", cnt_a, 5);
    check("t4_model_cnt", m_cnt[0], 5);
    check("t4_norepeat_extra_pulses", pulses, 0);
    check("t4_norepeat_cnt", cnt_b, 1);
    repeat (15) @(negedge clk);
    check("t4_release_level", level_a, 0);

    // 5: reset while held
    btn_in = 1'b1;
    wait_pulse(n);
    check("t5_press_latency", n, 7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_level", level_a, 0);
    check("t5_rst_pulse", pulse_a, 0);
    check("t5_rst_cnt", cnt_a, 0);
    check("t5_rst_cnt_b", cnt_b, 0);
    rst = 1'b0;
    wait_pulse(n);
    check("t5_repress_latency", n, 7);
    check("t5_cnt", cnt_a, 1);
    btn_in = 1'b0;
    repeat (15) @(negedge clk);

    // 6: counter wrap after 256 clean presses
    pulse_rst();
    pulses = 0;
    repeat (256) begin
      btn_in = 1'b1;
      repeat (8) begin
        @(negedge clk);
        if (pulse_a) pulses++;
      end
      btn_in = 1'b0;
      repeat (8) @(negedge clk);
    end
    check("t6_pulse_total", pulses, 256);
    check("t6_cnt_wrap", cnt_a, 0);
    check("t6_cnt_wrap_b", cnt_b, 0);
    check("t6_level", level_a, 0);

    // Random bursts and bounces with occasional resets
    repeat (300) begin
      btn_in = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
      if ($urandom_range(0, 39) == 0) rst = 1'b1;
      repeat (len) begin
        @(negedge clk);
        rst = 1'b0;
      end
    end
    btn_in = 1'b0;
    repeat (20) @(negedge clk);
    check("end_level", level_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
